// File: rtl/parity_pipe_arbiter.sv
// parity_pipe_arbiter
// Two-requester round-robin arbiter feeding a 3-stage pipeline:
//   S1 captures the granted byte and its requester id,
//   S2 adds the addend (modulo 256),
//   S3 registers the sum, its even-XOR parity and the id.
// A result waiting in S3 that the consumer does not take stalls every stage.
// Optional feature macro: PARITY_PIPE_ARBITER_CFG_ADDEND_EN
//   defined   -> run-time writable addend (resets to 0x55) with cfg_we,
//                cfg_addend and a one-cycle cfg_err pulse for rejected writes
//   undefined -> fixed addend 0x55, no configuration ports
module parity_pipe_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req1_valid,
  input  logic [7:0] req0_data,
  input  logic [7:0] req1_data,
  output logic       req0_ready,
  output logic       req1_ready,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_sum,
  output logic       res_parity,
  output logic       res_id,
  output logic       busy
`ifdef PARITY_PIPE_ARBITER_CFG_ADDEND_EN
  ,
  input  logic       cfg_we,
  input  logic [7:0] cfg_addend,
  output logic       cfg_err
`endif
);

  localparam logic [7:0] DEFAULT_ADDEND = 8'h55;

  // XOR reduction of a result byte
  function automatic logic parity8(input logic [7:0] value);
    return ^value;
  endfunction

  logic       s1_valid_r;
  logic [7:0] s1_data_r;
  logic       s1_id_r;
  logic       s2_valid_r;
  logic [7:0] s2_sum_r;
  logic       s2_id_r;
  logic       s3_valid_r;
  logic [7:0] s3_sum_r;
  logic       s3_parity_r;
  logic       s3_id_r;
  logic       last_grant_r;

  logic       stall_s;
  logic       grant0_s;
  logic       grant1_s;
  logic       accept_s;
  logic [7:0] acc_data_s;
  logic       acc_id_s;
  logic       busy_s;
  logic [7:0] addend_s;

  assign stall_s  = s3_valid_r & ~res_ready;
  assign busy_s   = s1_valid_r | s2_valid_r | s3_valid_r;
  // A grant is only ever issued to a valid requester, so a grant is an accept.
  assign accept_s = grant0_s | grant1_s;

  // Round-robin grant: a lone requester wins; on contention the one not last granted wins.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (!rst || stall_s) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else begin
      case ({req1_valid, req0_valid})
        2'b01:   grant0_s = 1'b1;
        2'b10:   grant1_s = 1'b1;
        2'b11: begin
          if (last_grant_r) begin
            grant0_s = 1'b1;
          end else begin
            grant1_s = 1'b1;
          end
        end
        default: begin
          grant0_s = 1'b0;
          grant1_s = 1'b0;
        end
      endcase
    end
  end

  // Select payload and id of the granted requester for S1.
  always_comb begin
    acc_data_s = 8'h00;
    acc_id_s   = 1'b0;
    if (grant1_s) begin
      acc_data_s = req1_data;
      acc_id_s   = 1'b1;
    end else begin
      acc_data_s = req0_data;
      acc_id_s   = 1'b0;
    end
  end

  // Last-grant pointer; reset value makes req0 win the first contention.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_r <= 1'b1;
    end else if (accept_s) begin
      last_grant_r <= grant1_s;
    end
  end

  // Three pipeline stages advancing together whenever the output is not stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_r  <= 1'b0;
      s1_data_r   <= 8'h00;
      s1_id_r     <= 1'b0;
      s2_valid_r  <= 1'b0;
      s2_sum_r    <= 8'h00;
      s2_id_r     <= 1'b0;
      s3_valid_r  <= 1'b0;
      s3_sum_r    <= 8'h00;
      s3_parity_r <= 1'b0;
      s3_id_r     <= 1'b0;
    end else if (!stall_s) begin
      s1_valid_r  <= accept_s;
      s1_data_r   <= acc_data_s;
      s1_id_r     <= acc_id_s;
      s2_valid_r  <= s1_valid_r;
      s2_sum_r    <= s1_data_r + addend_s;
      s2_id_r     <= s1_id_r;
      s3_valid_r  <= s2_valid_r;
      s3_sum_r    <= s2_sum_r;
      s3_parity_r <= parity8(s2_sum_r);
      s3_id_r     <= s2_id_r;
    end
  end

`ifdef PARITY_PIPE_ARBITER_CFG_ADDEND_EN
  logic [7:0] addend_r;
  logic       cfg_err_r;

  // Addend register: writes land only while the pipeline is empty and nothing
  // is being accepted, so every in-flight item uses one consistent addend.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addend_r  <= DEFAULT_ADDEND;
      cfg_err_r <= 1'b0;
    end else begin
      cfg_err_r <= 1'b0;
      if (cfg_we) begin
        if (busy_s || accept_s) begin
          cfg_err_r <= 1'b1;
        end else begin
          addend_r <= cfg_addend;
        end
      end
    end
  end

  assign addend_s = addend_r;
  assign cfg_err  = cfg_err_r;
`else
  assign addend_s = DEFAULT_ADDEND;
`endif

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign res_valid  = s3_valid_r;
  assign res_sum    = s3_sum_r;
  assign res_parity = s3_parity_r;
  assign res_id     = s3_id_r;
  assign busy       = busy_s;

endmodule

// File: tb/tb_parity_pipe_arbiter.sv
// Self-checking bench for parity_pipe_arbiter.
// Reference model: a queue of expected results in acceptance order, each with
// a count of unstalled edges since acceptance (visible once it reaches 2).
module tb_parity_pipe_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       res_valid, res_ready;
  logic [7:0] res_sum;
  logic       res_parity, res_id, busy;
`ifdef PARITY_PIPE_ARBITER_CFG_ADDEND_EN
  logic       cfg_we;
  logic [7:0] cfg_addend;
  logic       cfg_err;
`endif

  always #5 clk = ~clk;

  parity_pipe_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_data  (req0_data),
    .req1_data  (req1_data),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_parity (res_parity),
    .res_id     (res_id),
    .busy       (busy)
`ifdef PARITY_PIPE_ARBITER_CFG_ADDEND_EN
    ,
    .cfg_we     (cfg_we),
    .cfg_addend (cfg_addend),
    .cfg_err    (cfg_err)
`endif
  );

  typedef struct {
    logic [7:0] sum;
    logic       id;
    int         age;
  } item_t;

  item_t      q[$];
  logic       last_m;
  logic [7:0] addend_m;
  logic       err_m;
  int         checks = 0;
  int         errors = 0;

  function automatic logic front_visible();
    return (q.size() > 0) && (q[0].age >= 2);
  endfunction

  function automatic logic [1:0] exp_grant();
    logic st, g0, g1;
    st = front_visible() && !res_ready;
    g0 = rst && !st && req0_valid && (!req1_valid || last_m);
    g1 = rst && !st && req1_valid && (!req0_valid || !last_m);
    return {g1, g0};
  endfunction

  // Compare every observable output against the model (called mid-cycle).
  task automatic check_cycle();
    logic [1:0] g;
    logic       vis;
    g   = exp_grant();
    vis = front_visible();
    checks++;
    if (req0_ready !== g[0]) begin errors++; $display("FAIL req0_ready got %b exp %b t=%0t", req0_ready, g[0], $time); end
    checks++;
    if (req1_ready !== g[1]) begin errors++; $display("FAIL req1_ready got %b exp %b t=%0t", req1_ready, g[1], $time); end
    checks++;
    if (res_valid !== vis) begin errors++; $display("FAIL res_valid got %b exp %b t=%0t", res_valid, vis, $time); end
    checks++;
    if (busy !== (q.size() > 0)) begin errors++; $display("FAIL busy got %b exp %b t=%0t", busy, (q.size() > 0), $time); end
    if (vis) begin
      checks++;
      if (res_sum !== q[0].sum) begin errors++; $display("FAIL res_sum got %h exp %h t=%0t", res_sum, q[0].sum, $time); end
      checks++;
      if (res_parity !== ^q[0].sum) begin errors++; $display("FAIL res_parity got %b exp %b t=%0t", res_parity, ^q[0].sum, $time); end
      checks++;
      if (res_id !== q[0].id) begin errors++; $display("FAIL res_id got %b exp %b t=%0t", res_id, q[0].id, $time); end
    end
`ifdef PARITY_PIPE_ARBITER_CFG_ADDEND_EN
    checks++;
    if (cfg_err !== err_m) begin errors++; $display("FAIL cfg_err got %b exp %b t=%0t", cfg_err, err_m, $time); end
`endif
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_edge();
    logic [1:0] g;
    logic       was_busy;
    item_t      it;
    g        = exp_grant();
    was_busy = (q.size() > 0);
`ifdef PARITY_PIPE_ARBITER_CFG_ADDEND_EN
    err_m = 1'b0;
    if (cfg_we) begin
      if (was_busy || (g != 2'b00)) err_m = 1'b1;
      else                          addend_m = cfg_addend;
    end
`endif
    if (!(front_visible() && !res_ready)) begin
      if (front_visible()) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (g != 2'b00) begin
        it.id  = g[1];
        it.sum = (g[1] ? req1_data : req0_data) + addend_m;
        it.age = 0;
        q.push_back(it);
        last_m = g[1];
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Cycle that additionally requires a specific result to be presented.
  task automatic cycle_expect(input logic [7:0] s, input logic p, input logic id);
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || res_sum !== s || res_parity !== p || res_id !== id) begin
      errors++;
      $display("FAIL result got v=%b sum=%h par=%b id=%b exp v=1 sum=%h par=%b id=%b", res_valid, res_sum, res_parity, res_id, s, p, id);
    end
    check_cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = 8'h00;
    req1_data  = 8'h00;
    res_ready  = 1'b1;
`ifdef PARITY_PIPE_ARBITER_CFG_ADDEND_EN
    cfg_we     = 1'b0;
    cfg_addend = 8'h00;
`endif
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    idle_inputs();
    #1;
    q.delete();
    last_m   = 1'b1;
    addend_m = 8'h55;
    err_m    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    idle_inputs();
    while (q.size() > 0 && n < 20) begin
      cycle();
      n++;
    end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL drain_timeout got %0d left exp 0", q.size()); q.delete(); end
    cycle();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #2;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b%b exp 00", req1_ready, req0_ready); end
    checks++;
    if (res_valid !== 1'b0 || res_sum !== 8'h00 || res_parity !== 1'b0 || res_id !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b sum=%h par=%b id=%b busy=%b exp all zero", res_valid, res_sum, res_parity, res_id, busy);
    end
    apply_reset();
  endtask

  task automatic test_single();
    req0_valid = 1'b1;
    req0_data  = 8'h00;
    cycle();
    idle_inputs();
    cycle();
    cycle();
    cycle_expect(8'h55, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_wrap();
    req1_valid = 1'b1;
    req1_data  = 8'hAB;
    cycle();
    idle_inputs();
    cycle();
    cycle();
    cycle_expect(8'h00, 1'b0, 1'b1);
    req0_valid = 1'b1;
    req0_data  = 8'hFF;
    cycle();
    idle_inputs();
    cycle();
    cycle();
    cycle_expect(8'h54, 1'b1, 1'b0);
    drain();
  endtask

  task automatic test_contention();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      req0_data  = 8'($urandom_range(0, 255));
      req1_data  = 8'($urandom_range(0, 255));
      @(negedge clk);
      checks++;
      if (req0_ready !== ((i % 2) == 0) || req1_ready !== ((i % 2) == 1)) begin
        errors++;
        $display("FAIL contention_alt got %b%b exp %b%b i=%0d", req1_ready, req0_ready, (i % 2) == 1, (i % 2) == 0, i);
      end
      check_cycle();
      @(posedge clk);
      model_edge();
      #1;
    end
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      req0_valid = 1'b1;
      req0_data  = 8'($urandom_range(0, 255));
      @(negedge clk);
      checks++;
      if (req0_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1 i=%0d", req0_ready, i); end
      check_cycle();
      @(posedge clk);
      model_edge();
      #1;
    end
    drain();
  endtask

  task automatic test_stall();
    logic [7:0] s_sum;
    logic       s_par, s_id;
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1'b1;
      req0_data  = 8'($urandom_range(0, 255));
      cycle();
    end
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        s_sum = res_sum;
        s_par = res_parity;
        s_id  = res_id;
      end
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || res_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold got r=%b%b v=%b exp r=00 v=1", req1_ready, req0_ready, res_valid);
      end
      checks++;
      if (res_sum !== s_sum || res_parity !== s_par || res_id !== s_id) begin
        errors++;
        $display("FAIL stall_stable got %h/%b/%b exp %h/%b/%b", res_sum, res_parity, res_id, s_sum, s_par, s_id);
      end
      check_cycle();
      @(posedge clk);
      model_edge();
      #1;
    end
    drain();
  endtask

  task automatic test_reset_mid();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 8'h11;
    req1_data  = 8'h22;
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_mid got v=%b busy=%b exp 0 0", res_valid, busy); end
    apply_reset();
    for (int i = 0; i < 5; i++) cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_data  = 8'($urandom_range(0, 255));
      req1_data  = 8'($urandom_range(0, 255));
      res_ready  = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();
  endtask

`ifdef PARITY_PIPE_ARBITER_CFG_ADDEND_EN
  task automatic test_cfg();
    cfg_we     = 1'b1;
    cfg_addend = 8'h01;
    cycle();
    cfg_we = 1'b0;
    cycle();
    req0_valid = 1'b1;
    req0_data  = 8'h7F;
    cycle();
    idle_inputs();
    cycle();
    cycle();
    cycle_expect(8'h80, 1'b1, 1'b0);
    drain();
    req0_valid = 1'b1;
    req0_data  = 8'h10;
    cycle();
    idle_inputs();
    cfg_we     = 1'b1;
    cfg_addend = 8'h33;
    cycle();
    cfg_we = 1'b0;
    @(negedge clk);
    checks++;
    if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_busy got %b exp 1", cfg_err); end
    check_cycle();
    @(posedge clk);
    model_edge();
    #1;
    cycle_expect(8'h11, 1'b0, 1'b0);
    drain();
    req0_valid = 1'b1;
    req0_data  = 8'h7F;
    cycle();
    idle_inputs();
    cycle();
    cycle();
    cycle_expect(8'h80, 1'b1, 1'b0);
    drain();
    apply_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_contention();
    test_back_to_back();
    test_stall();
    test_reset_mid();
`ifdef PARITY_PIPE_ARBITER_CFG_ADDEND_EN
    test_cfg();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
